// File: rtl/clock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// clock_reset_sequencer
//
// Start-up sequencer running on the 56 MHz PLL output clock. It synchronises
// and qualifies the PLL lock flag, holds the system in reset for a fixed
// power-on period, then releases reset and generates the 7 MHz / 3.5 MHz
// clock-enable strobes. Core logic may request a soft reset while running, and
// any loss of lock returns the block to WAIT_LOCK.
//
// Ports:
//   clock      in   56 MHz system clock
//   reset      in   asynchronous active-low reset
//   locked     in   PLL lock, asynchronous to clock
//   softReset  in   soft-reset request (level, active-high, honoured in RUN)
//   sysReset   out  system reset, active-low, registered
//   ready      out  high while in RUN, registered
//   ce7p/ce7n  out  7 MHz positive/negative phase enables (one clock wide)
//   ce3p/ce3n  out  3.5 MHz positive/negative phase enables
//   state      out  current state for debug
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_LOCK  | waiting for synchronised lock; counter held at 0
// STABLE     | lock seen; must stay high for LOCK_CYCLES consecutive cycles
// PORST      | lock trusted; sysReset held low for POR_CYCLES cycles
// RUN        | sysReset released, strobes running
// -----------------------------------------------------------------------------
module clock_reset_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int POR_CYCLES  = 65536
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic       softReset,
  output logic       sysReset,
  output logic       ready,
  output logic       ce7p,
  output logic       ce7n,
  output logic       ce3p,
  output logic       ce3n,
  output logic [1:0] state
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > POR_CYCLES) ? LOCK_CYCLES : POR_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] LOCK_TC = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] POR_TC  = CW'(POR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_PORST     = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_locked_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [3:0]    r_cc;
  logic [3:0]    w_cc_next;
  logic          r_sys_reset;
  logic          r_ready;
  logic          w_run;

  // Two-flop synchroniser: the only place the raw lock flag is sampled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_locked_s = r_sync2;

  // State register, with the counter, divider and registered outputs that
  // follow the next state so they change on the same edge as the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_cc        <= '0;
      r_sys_reset <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_cc        <= w_cc_next;
      r_sys_reset <= (w_state_next == S_RUN);
      r_ready     <= (w_state_next == S_RUN);
    end
  end

  // Next-state logic. Lock loss beats softReset beats counter terminal.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT_LOCK: begin
        if (w_locked_s) w_state_next = S_STABLE;
      end
      S_STABLE: begin
        if (!w_locked_s)           w_state_next = S_WAIT_LOCK;
        else if (r_cnt == LOCK_TC) w_state_next = S_PORST;
      end
      S_PORST: begin
        if (!w_locked_s)          w_state_next = S_WAIT_LOCK;
        else if (r_cnt == POR_TC) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (!w_locked_s)    w_state_next = S_WAIT_LOCK;
        else if (softReset) w_state_next = S_PORST;
      end
      default: w_state_next = S_WAIT_LOCK;
    endcase
  end

  // Counter and divider: both restart at 0 on every state change, so a state
  // always starts from a clean count and the first RUN cycle has cc=0.
  always_comb begin
    w_cnt_next = '0;
    w_cc_next  = '0;
    if ((r_state == S_STABLE || r_state == S_PORST) && (w_state_next == r_state))
      w_cnt_next = r_cnt + 1'b1;
    if ((r_state == S_RUN) && (w_state_next == S_RUN))
      w_cc_next = r_cc + 1'b1;
  end

  // Output decode: strobes are combinational from registered cc and state.
  always_comb begin
    w_run = (r_state == S_RUN);
    ce7p  = w_run && (r_cc[2:0] == 3'd7);
    ce7n  = w_run && (r_cc[2:0] == 3'd3);
    ce3p  = w_run && (r_cc == 4'd15);
    ce3n  = w_run && (r_cc == 4'd7);
  end

  assign sysReset = r_sys_reset;
  assign ready    = r_ready;
  assign state    = r_state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clock_reset_sequencer
//
// Bench for clock_reset_sequencer with LOCK_CYCLES=4, POR_CYCLES=8. A model
// describes the sequencer as "time elapsed since lock was first trusted" and
// derives state, reset and strobes from that with plain arithmetic. A compare
// process checks every falling edge; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_clock_reset_sequencer;

  localparam int L = 4;
  localparam int P = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       softReset = 1'b0;
  logic       sysReset;
  logic       ready;
  logic       ce7p;
  logic       ce7n;
  logic       ce3p;
  logic       ce3n;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  clock_reset_sequencer #(
    .LOCK_CYCLES(L),
    .POR_CYCLES (P)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .locked   (locked),
    .softReset(softReset),
    .sysReset (sysReset),
    .ready    (ready),
    .ce7p     (ce7p),
    .ce7n     (ce7n),
    .ce3p     (ce3p),
    .ce3n     (ce3n),
    .state    (state)
  );

  always #9 clock = ~clock;

  // ---------------------------------------------------------------- model
  // m_active: lock has been seen (synchronised) and not lost since.
  // m_elapsed: cycles since the sequence started; 0..L-1 STABLE,
  // L..L+P-1 PORST, beyond that RUN. A soft reset rewinds to L.
  bit m_active  = 1'b0;
  int m_elapsed = 0;
  bit m_s1      = 1'b0;
  bit m_ls      = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active  = 1'b0;
      m_elapsed = 0;
      m_s1      = 1'b0;
      m_ls      = 1'b0;
    end else begin
      if (!m_active) begin
        if (m_ls) begin
          m_active  = 1'b1;
          m_elapsed = 0;
        end
      end else if (!m_ls) begin
        m_active = 1'b0;
      end else if (m_elapsed >= L + P && softReset) begin
        m_elapsed = L;
      end else begin
        m_elapsed++;
      end
      // lock flag delayed by two edges
      m_ls = m_s1;
      m_s1 = locked;
    end
  end

  function automatic logic [7:0] model_vec();
    int st;
    int cc;
    bit run;
    if (!m_active)             st = 0;
    else if (m_elapsed < L)    st = 1;
    else if (m_elapsed < L + P) st = 2;
    else                       st = 3;
    run = (st == 3);
    cc  = run ? ((m_elapsed - L - P) % 16) : 0;
    model_vec = {st[1:0], run, run,
                 run && (cc % 8 == 7), run && (cc % 8 == 3),
                 run && (cc == 15),    run && (cc == 7)};
  endfunction

  function automatic logic [7:0] dut_vec();
    dut_vec = {state, sysReset, ready, ce7p, ce7n, ce3p, ce3n};
  endfunction

  always @(negedge clock) begin
    logic [7:0] exp_v;
    logic [7:0] act_v;
    exp_v = model_vec();
    act_v = dut_vec();
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t actual={st,sys,rdy,7p,7n,3p,3n}=%b required=%b",
               $time, act_v, exp_v);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Watches the state trace until RUN is reached; reports the length of the
  // most recent contiguous WAIT_LOCK, STABLE and PORST runs.
  task automatic wait_run(input int budget, output int wl, output int sl,
                          output int pl, output bit ok);
    int prev;
    int run;
    prev = -1;
    run  = 0;
    wl = 0; sl = 0; pl = 0; ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (int'(state) == prev) run++;
      else run = 1;
      prev = int'(state);
      if (state == 2'd0) wl = run;
      if (state == 2'd1) sl = run;
      if (state == 2'd2) pl = run;
      if (state == 2'd3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int exp_tr[15] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3};
    int rise;
    int n7p, n7n, n3p, n3n, f7p, f7n, f3p, f3n, both;
    int low, drop, wl, sl, pl, run_seen, soft_hold;
    bit ok, found;

    // Power-up
    #1 reset = 1'b0;
    locked = 1'b1;
    repeat (5) @(posedge clock);
    #1 chk("reset_outputs", int'(dut_vec()), 0);
    #1 reset = 1'b1;
    rise = -1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("pwr_state_e%0d", k), int'(state), exp_tr[k]);
      if (rise < 0 && sysReset) rise = k;
    end
    chk("pwr_sysreset_rise_edge", rise, 14);

    // Strobes over 32 RUN cycles (first sample is RUN cycle 0)
    n7p = 0; n7n = 0; n3p = 0; n3n = 0; both = 0;
    f7p = -1; f7n = -1; f3p = -1; f3n = -1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clock);
      if (ce7p) begin n7p++; if (f7p < 0) f7p = i; end
      if (ce7n) begin n7n++; if (f7n < 0) f7n = i; end
      if (ce3p) begin n3p++; if (f3p < 0) f3p = i; end
      if (ce3n) begin n3n++; if (f3n < 0) f3n = i; end
      if (ce7p && ce7n) both++;
    end
    chk("ce7p_count", n7p, 4);
    chk("ce7n_count", n7n, 4);
    chk("ce3p_count", n3p, 2);
    chk("ce3n_count", n3n, 2);
    chk("ce7p_first", f7p, 7);
    chk("ce7n_first", f7n, 3);
    chk("ce3p_first", f3p, 15);
    chk("ce3n_first", f3n, 7);
    chk("ce7p_ce7n_overlap", both, 0);

    // Soft reset for one cycle
    softReset = 1'b1;
    @(negedge clock);
    softReset = 1'b0;
    chk("soft_sysreset", int'(sysReset), 0);
    chk("soft_state", int'(state), 2);
    chk("soft_ce", int'({ce7p, ce7n, ce3p, ce3n}), 0);
    low = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (sysReset) break;
      low++;
    end
    chk("soft_por_len", low, 8);
    f7n = -1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      if (ce7n && f7n < 0) f7n = i;
    end
    chk("soft_cc_restart_ce7n", f7n, 3);

    // Lock loss in RUN; softReset lands on the edge where the synchronised
    // drop is seen, so lock loss must win.
    locked = 1'b0;
    drop = -1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (drop < 0 && !sysReset) drop = k;
      if (k == 3) chk("loss_state", int'(state), 0);
      softReset = (k == 2);
    end
    chk("loss_edges", drop, 3);
    chk("loss_state_hold", int'(state), 0);

    // Lock glitch during the second STABLE cycle
    locked = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (state == 2'd1) found = 1'b1;
    end
    chk("glitch_reach_stable", int'(found), 1);
    @(negedge clock);
    locked = 1'b0;
    @(negedge clock);
    locked = 1'b1;
    wait_run(100, wl, sl, pl, ok);
    chk("glitch_run", int'(ok), 1);
    chk("glitch_wait_len", wl, 1);
    chk("glitch_stable_len", sl, 4);
    chk("glitch_por_len", pl, 8);

    // Async reset mid-PORST
    softReset = 1'b1;
    @(negedge clock);
    softReset = 1'b0;
    repeat (3) @(negedge clock);
    chk("async_pre_state", int'(state), 2);
    #3 reset = 1'b0;
    #1 chk("async_reset_outputs", int'(dut_vec()), 0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    wait_run(60, wl, sl, pl, ok);
    chk("async_run", int'(ok), 1);
    chk("async_wait_len", wl, 3);
    chk("async_stable_len", sl, 4);
    chk("async_por_len", pl, 8);

    // Randomised phase, checked by the model every cycle
    run_seen = 0;
    soft_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (state == 2'd3) run_seen++;
      if (locked) locked = ($urandom_range(0, 299) != 0);
      else        locked = ($urandom_range(0, 3) == 0);
      if (soft_hold > 0) begin
        soft_hold--;
        softReset = 1'b1;
      end else begin
        softReset = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 399) == 0) soft_hold = $urandom_range(10, 40);
      end
      if ($urandom_range(0, 999) == 0) begin
        #3 reset = 1'b0;
        #1 chk("rand_async_reset", int'(dut_vec()), 0);
        @(posedge clock);
        #2 reset = 1'b1;
      end
    end
    chk("rand_run_seen", int'(run_seen > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
